// File: rtl/iterative_shifter.sv
// Multi-cycle 32-bit shifter: one power-of-two stage (16,8,4,2,1) per clock.
// Optional macro ITERATIVE_SHIFTER_SRL_EN enables logical right shift on op 10.
module iterative_shifter #(
    parameter int WIDTH   = 32,
    parameter int NSTAGES = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ctrl_shift,
    input  logic [1:0]         ctrl_shiftop,
    input  logic [NSTAGES-1:0] ctrl_shiftamt,
    input  logic [WIDTH-1:0]   data_operandA,
    output logic [WIDTH-1:0]   data_result,
    output logic               data_resultRDY,
    output logic               busy
);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    localparam logic [2:0] LAST_STAGE = 3'd4;

    state_t             state;
    state_t             state_next;
    logic [2:0]         stage;
    logic [WIDTH-1:0]   work;
    logic [WIDTH-1:0]   work_next;
    logic [NSTAGES-1:0] amt;
    logic [1:0]         op;
    logic               stage_en;
    logic               last_stage;
    logic [WIDTH-1:0]   sll_val;
    logic [WIDTH-1:0]   sra_val;
`ifdef ITERATIVE_SHIFTER_SRL_EN
    logic [WIDTH-1:0]   srl_val;
`endif

    assign busy       = (state == SHIFT);
    assign last_stage = (state == SHIFT) && (stage == LAST_STAGE);

    // Stage k shifts by 16>>k and is enabled by amount bit (4-k).
    always_comb begin
        stage_en = 1'b0;
        sll_val  = work;
        sra_val  = work;
        case (stage)
            3'd0: begin
                stage_en = amt[4];
                sll_val  = {work[15:0], 16'b0};
                sra_val  = {{16{work[31]}}, work[31:16]};
            end
            3'd1: begin
                stage_en = amt[3];
                sll_val  = {work[23:0], 8'b0};
                sra_val  = {{8{work[31]}}, work[31:8]};
            end
            3'd2: begin
                stage_en = amt[2];
                sll_val  = {work[27:0], 4'b0};
                sra_val  = {{4{work[31]}}, work[31:4]};
            end
            3'd3: begin
                stage_en = amt[1];
                sll_val  = {work[29:0], 2'b0};
                sra_val  = {{2{work[31]}}, work[31:2]};
            end
            3'd4: begin
                stage_en = amt[0];
                sll_val  = {work[30:0], 1'b0};
                sra_val  = {work[31], work[31:1]};
            end
            default: begin
                stage_en = 1'b0;
            end
        endcase
    end

`ifdef ITERATIVE_SHIFTER_SRL_EN
    always_comb begin
        srl_val = work;
        case (stage)
            3'd0:    srl_val = {16'b0, work[31:16]};
            3'd1:    srl_val = {8'b0, work[31:8]};
            3'd2:    srl_val = {4'b0, work[31:4]};
            3'd3:    srl_val = {2'b0, work[31:2]};
            3'd4:    srl_val = {1'b0, work[31:1]};
            default: srl_val = work;
        endcase
    end
`endif

    // Anything not decoded as a real shift passes the working value through.
    always_comb begin
        work_next = work;
        if (stage_en) begin
            case (op)
                2'b00:   work_next = sll_val;
                2'b01:   work_next = sra_val;
`ifdef ITERATIVE_SHIFTER_SRL_EN
                2'b10:   work_next = srl_val;
`endif
                default: work_next = work;
            endcase
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ctrl_shift) state_next = SHIFT;
            SHIFT:   if (stage == LAST_STAGE) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Starts while busy are dropped because operands load only in IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage          <= 3'd0;
            work           <= '0;
            amt            <= '0;
            op             <= 2'b00;
            data_result    <= '0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (state == IDLE) begin
                if (ctrl_shift) begin
                    work  <= data_operandA;
                    amt   <= ctrl_shiftamt;
                    op    <= ctrl_shiftop;
                    stage <= 3'd0;
                end
            end else begin
                work  <= work_next;
                stage <= stage + 3'd1;
                if (last_stage) begin
                    data_result    <= work_next;
                    data_resultRDY <= 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/iterative_shifter.md
Name: iterative_shifter

Overview:
- Multi-cycle 32-bit shift unit in the ALU datapath.
- Applies the fixed power-of-two shift stages (16, 8, 4, 2, 1) one per clock, selected by bits of ctrl_shiftamt.
- Replaces the single-cycle combinational barrel cascade where timing requires it.
- Consumes operand A and the shift amount from the decode/issue stage; its result feeds the ALU result mux with a ready pulse.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported, because the stage set 16/8/4/2/1 is fixed.
- NSTAGES, 5, number of shift stages. Equals the width of ctrl_shiftamt.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- ctrl_shift  input  1  start request; sampled only in IDLE.
- ctrl_shiftop  input  2  op select: 00 SLL, 01 SRA, 10 SRL (optional), 11 pass-through.
- ctrl_shiftamt  input  5  shift amount, 0..31.
- data_operandA  input  32  operand to shift.
- data_result  output  32  shifted result; holds its value until the next completion.
- data_resultRDY  output  1  one-cycle pulse when data_result is updated.
- busy  output  1  high while an operation is in flight.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - state IDLE, stage counter 0;
  - data_result = 0, data_resultRDY = 0, busy = 0;
  - internal operand, amount and op registers = 0.
- States are IDLE and SHIFT.
- busy = (state == SHIFT), decoded from registered state.
- IDLE:
  - If ctrl_shift = 1 at an edge, latch data_operandA, ctrl_shiftamt and ctrl_shiftop; clear the counter; go to SHIFT.
  - Otherwise stay in IDLE.
- SHIFT: at each edge, apply stage k = counter (k=0: 16, 1: 8, 2: 4, 3: 2, 4: 1) to the working register.
  - The stage is applied only if amount bit (4-k) = 1; otherwise the register passes through.
  - The counter increments each edge.
  - At the edge where k = 4: write the final value into data_result, drive data_resultRDY = 1 for the next cycle, return to IDLE.
- Latency: with start sampled at edge 0, the stages run at edges 1..5. data_result is valid and data_resultRDY is high in the cycle after edge 5. A new start is accepted at edge 6 (throughput: one op per 6 cycles).
- Stage semantics at distance d:
  - SLL: zero-fill the low d bits.
  - SRA: fill the vacated high d bits with bit 31 of the working register.
  - SRL: zero-fill the vacated high bits.
  - Pass-through (11, or 10 when the feature is off): no stage alters the value; the full 5-cycle latency still applies.
- data_resultRDY is deasserted at every edge except the completion edge, so it is never high for two consecutive cycles.
- ctrl_shift while busy is ignored and not queued. Inputs changing during SHIFT have no effect (latched copies are used).
- Amount 0: result = operand, latency unchanged.
- Reset mid-operation: aborts immediately. No RDY pulse; data_result is 0.
- Simultaneous ctrl_shift and completion: the unit is still in SHIFT at that edge, so the start is ignored.

Optional Feature:
- Macro: ITERATIVE_SHIFTER_SRL_EN.
- Defined: op 10 performs a logical right shift (zero fill).
- Not defined: op 10 decodes as pass-through, and no SRL fill logic is instantiated.

Test Plan:
- SRA, operand 0x80000000, amount 16 -> data_result = 0xFFFF8000. data_resultRDY is high exactly one cycle, 6 cycles after the start edge; busy is high for 5 cycles.
- SLL, operand 0x00000001, amount 31 -> 0x80000000. SRA, operand 0x7FFFFFFF, amount 31 -> 0x00000000. SRA, operand 0xF0000000, amount 4 -> 0xFF000000.
- Amount 0 with op SLL, and op 11 with amount 7, on operand 0xDEADBEEF -> 0xDEADBEEF in both cases, with the same 6-cycle timing.
- Start an SLL (operand 0x1, amount 1); re-pulse ctrl_shift with operand 0xFFFFFFFF on cycles 2..4 -> result 0x00000002. Exactly one RDY pulse; the second request is dropped.
- Assert reset at cycle 3 of an SRA on 0x80000000 by 8 -> busy = 0 and data_result = 0 immediately; no RDY pulse. After release, a new SLL of 0x3 by 2 -> 0x0000000C.
- Op 10, operand 0x80000000, amount 4 -> 0x08000000 with ITERATIVE_SHIFTER_SRL_EN; 0x80000000 (pass-through) without it.
